// File: rtl/sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sched_pkg
// Description : Shared constants, state encoding and qid helpers for the
//               queue drain scheduler.
// Revision    : 1.0
// ============================================================================
package sched_pkg;

   localparam int NUM_Q  = 4;
   localparam int DATA_W = 2;
   localparam int QID_W  = 2;

   typedef logic [QID_W-1:0] qid_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OFFER = 2'd1,
      POP   = 2'd2,
      WAIT  = 2'd3
   } state_t;

   function automatic logic [NUM_Q-1:0] qid_onehot(input qid_t q);
      return NUM_Q'(1) << q;
   endfunction

endpackage
`default_nettype wire

// File: rtl/queue_drain_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker; searches ptr+1, ptr+2, ...
//               modulo NUM_Q and returns the first requesting buffer.
// Revision    : 1.0
// ============================================================================
module rr_arbiter
   import sched_pkg::*;
(
   input  logic [NUM_Q-1:0] req,
   input  logic [QID_W-1:0] ptr,
   output logic [NUM_Q-1:0] gnt_onehot,
   output logic [QID_W-1:0] gnt_idx,
   output logic             any
);

   logic [QID_W-1:0] w_cand;

   always_comb begin
      gnt_idx = '0;
      any     = 1'b0;
      w_cand  = '0;
      // Candidate wraps naturally because it is QID_W bits wide.
      for (int i = 1; i <= NUM_Q; i++) begin
         w_cand = ptr + QID_W'(i);
         if (!any && req[w_cand]) begin
            gnt_idx = w_cand;
            any     = 1'b1;
         end
      end
      gnt_onehot = any ? qid_onehot(gnt_idx) : '0;
   end

endmodule
`default_nettype wire

// File: rtl/queue_drain_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : queue_drain_scheduler
// Description : Round-robin drain of four packet buffers onto a paced
//               valid/ready output. Per-buffer counters under SCHED_STATS_EN.
// Revision    : 1.0
// ============================================================================
module queue_drain_scheduler
   import sched_pkg::*;
#(
   parameter int PERIOD = 8,
   parameter int CNT_W  = 8
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [NUM_Q-1:0]       q_valid,
   input  logic [NUM_Q*DATA_W-1:0] q_data,
   output logic [NUM_Q-1:0]       q_pop,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_data,
   output logic [QID_W-1:0]       out_qid,
   output logic [CNT_W-1:0]       served_total,
   output logic                   busy,
   output logic [NUM_Q*CNT_W-1:0] stats_o
);

   localparam logic [7:0] c_wait_load = 8'(PERIOD - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [QID_W-1:0]  r_ptr;
   logic [QID_W-1:0]  r_gnt;
   logic [NUM_Q-1:0]  r_gnt_oh;
   logic [7:0]        r_wait_cnt;
   logic [NUM_Q-1:0]  r_q_pop;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic [CNT_W-1:0]  r_served;

   logic [NUM_Q-1:0]  w_gnt_onehot;
   logic [QID_W-1:0]  w_gnt_idx;
   logic              w_any;
   logic [DATA_W-1:0] w_head_data;
   logic              w_load;
   logic              w_fire;
   logic              w_abort;

   rr_arbiter u_arb (
      .req        (q_valid),
      .ptr        (r_ptr),
      .gnt_onehot (w_gnt_onehot),
      .gnt_idx    (w_gnt_idx),
      .any        (w_any)
   );

   assign w_head_data = q_data[w_gnt_idx*DATA_W +: DATA_W];

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_fire      = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         IDLE: begin
            if (en && w_any) begin
               w_load      = 1'b1;
               w_state_nxt = OFFER;
            end
         end
         OFFER: begin
            // A handshake takes priority over a simultaneous buffer flush.
            if (r_out_valid && out_ready) begin
               w_fire      = 1'b1;
               w_state_nxt = POP;
            end else if (!q_valid[r_gnt]) begin
               w_abort     = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         POP: begin
            w_state_nxt = WAIT;
         end
         WAIT: begin
            if (r_wait_cnt == 8'd0) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_ptr       <= QID_W'(NUM_Q - 1);
         r_gnt       <= '0;
         r_gnt_oh    <= '0;
         r_wait_cnt  <= '0;
         r_q_pop     <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_served    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_q_pop <= '0;
         if (w_load) begin
            r_gnt       <= w_gnt_idx;
            r_gnt_oh    <= w_gnt_onehot;
            r_out_data  <= w_head_data;
            r_out_valid <= 1'b1;
         end
         if (w_fire) begin
            r_out_valid <= 1'b0;
            r_q_pop     <= r_gnt_oh;
            r_ptr       <= r_gnt;
            if (r_served != '1) begin
               r_served <= r_served + CNT_W'(1);
            end
         end
         if (w_abort) begin
            r_out_valid <= 1'b0;
         end
         if (r_state == POP) begin
            r_wait_cnt <= c_wait_load;
         end else if (r_state == WAIT && r_wait_cnt != 8'd0) begin
            r_wait_cnt <= r_wait_cnt - 8'd1;
         end
      end
   end

   assign q_pop        = r_q_pop;
   assign out_valid    = r_out_valid;
   assign out_data     = r_out_data;
   assign out_qid      = r_gnt;
   assign served_total = r_served;
   assign busy         = (r_state != IDLE);

`ifdef SCHED_STATS_EN
   generate
      for (genvar gi = 0; gi < NUM_Q; gi++) begin : g_stats
         logic [CNT_W-1:0] r_cnt;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_cnt <= '0;
            end else if (w_fire && r_gnt == QID_W'(gi) && r_cnt != '1) begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
         assign stats_o[CNT_W*gi +: CNT_W] = r_cnt;
      end
   endgenerate
`else
   assign stats_o = '0;
`endif

endmodule
`default_nettype wire
